data_ram_ctrl: RTL

DATA_RAM_CTRL -- requirements
Module: data_ram_ctrl

---
 rtl/data_ram_ctrl.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/data_ram_ctrl.sv
// Byte-addressable data RAM controller for a RISC-V style load/store unit.
// Clears the whole array after reset, then serves one access per cycle with a registered response.
module data_ram_ctrl #(
    parameter int TAM_POSICIONES = 1024,
    parameter int TAM_PALABRA    = 32,
    localparam int AW            = $clog2(TAM_POSICIONES) + 2
) (
    input  logic                   CLK,
    input  logic                   RSTa,
    input  logic                   REQ,
    input  logic                   WE,
    input  logic [2:0]             FUNCT3,
    input  logic [AW-1:0]          ADDR,
    input  logic [TAM_PALABRA-1:0] DATA_IN,
    output logic                   READY,
    output logic                   VALID,
    output logic                   ERR,
    output logic [TAM_PALABRA-1:0] DATA_OUT
);

    localparam int IW = $clog2(TAM_POSICIONES);
    localparam int NL = TAM_PALABRA / 8;
    localparam logic [IW-1:0] LAST_WORD = IW'(TAM_POSICIONES - 1);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t                 state_q, state_d;
    logic [IW-1:0]          cnt_q, cnt_d;
    logic                   valid_q, valid_d;
    logic                   err_q, err_d;
    logic [TAM_PALABRA-1:0] data_out_q, data_out_d;

    logic [TAM_PALABRA-1:0] mem [TAM_POSICIONES];

    logic                   mem_we;
    logic [IW-1:0]          mem_addr;
    logic [NL-1:0]          mem_be;
    logic [TAM_PALABRA-1:0] mem_wdata;

    logic [IW-1:0]          word_idx;
    logic [1:0]             byte_off;
    logic                   req_err;
    logic [NL-1:0]          st_be;
    logic [TAM_PALABRA-1:0] st_wdata;
    logic [TAM_PALABRA-1:0] rd_word;
    logic [7:0]             rd_byte;
    logic [15:0]            rd_half;
    logic [TAM_PALABRA-1:0] load_data;

    assign word_idx = ADDR[AW-1:2];
    assign byte_off = ADDR[1:0];
    assign rd_word  = mem[word_idx];
    assign rd_byte  = rd_word[{byte_off, 3'b000} +: 8];
    assign rd_half  = byte_off[1] ? rd_word[31:16] : rd_word[15:0];

    // Unsupported widths, stores of unsigned widths and misaligned H/W are rejected.
    always_comb begin
        req_err = 1'b0;
        case (FUNCT3)
            F3_B:    req_err = 1'b0;
            F3_H:    req_err = ADDR[0];
            F3_W:    req_err = |byte_off;
            F3_BU:   req_err = WE;
            F3_HU:   req_err = WE | ADDR[0];
            default: req_err = 1'b1;
        endcase
    end

    // Store data is replicated across lanes; the byte enables pick which lanes land.
    for (genvar gi = 0; gi < NL; gi++) begin : g_lane
        always_comb begin
            st_be[gi]             = 1'b0;
            st_wdata[8*gi +: 8]   = DATA_IN[8*gi +: 8];
            case (FUNCT3)
                F3_B: begin
                    st_be[gi]           = (byte_off == 2'(gi));
                    st_wdata[8*gi +: 8] = DATA_IN[7:0];
                end
                F3_H: begin
                    st_be[gi]           = (byte_off[1] == 1'(gi / 2));
                    st_wdata[8*gi +: 8] = DATA_IN[8*(gi % 2) +: 8];
                end
                F3_W: begin
                    st_be[gi]           = 1'b1;
                end
                default: begin
                    st_be[gi]           = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        load_data = rd_word;
        case (FUNCT3)
            F3_B:    load_data = {{(TAM_PALABRA-8){rd_byte[7]}}, rd_byte};
            F3_BU:   load_data = {{(TAM_PALABRA-8){1'b0}}, rd_byte};
            F3_H:    load_data = {{(TAM_PALABRA-16){rd_half[15]}}, rd_half};
            F3_HU:   load_data = {{(TAM_PALABRA-16){1'b0}}, rd_half};
            default: load_data = rd_word;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        data_out_d = data_out_q;
        mem_we     = 1'b0;
        mem_addr   = cnt_q;
        mem_be     = '0;
        mem_wdata  = '0;
        case (state_q)
            ST_INIT: begin
                mem_we = 1'b1;
                mem_be = '1;
                if (cnt_q == LAST_WORD) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (REQ) begin
                    valid_d = 1'b1;
                    if (req_err) begin
                        err_d      = 1'b1;
                        data_out_d = '0;
                    end else if (WE) begin
                        mem_we    = 1'b1;
                        mem_addr  = word_idx;
                        mem_be    = st_be;
                        mem_wdata = st_wdata;
                    end else begin
                        data_out_d = load_data;
                    end
                end
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            state_q    <= ST_INIT;
            cnt_q      <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            data_out_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            data_out_q <= data_out_d;
        end
    end

    // The array itself is never reset; the INIT sweep defines its contents.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            for (int i = 0; i < NL; i++) begin
                if (mem_be[i]) begin
                    mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    assign READY    = (state_q == ST_RUN);
    assign VALID    = valid_q;
    assign ERR      = err_q;
    assign DATA_OUT = data_out_q;

endmodule
